// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Brief    : IF stage; owns the PC, drives the instruction ROM and loads IF/ID.
//            Define IF_EARLY_JUMP_EN to resolve unconditional J inside IF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  J_OPCODE = 6'b010010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] w_pc4;
    logic        w_is_j;
    logic [8:0]  w_unused_bits;

    assign w_pc4    = pc_q + 32'd4;
    assign w_is_j   = (rom_inst[31:26] == J_OPCODE);
    assign rom_addr = pc_q;
    assign id_inst  = id_inst_q;
    assign id_pc4   = id_pc4_q;
    assign id_valid = id_valid_q;

    // Redirect targets are word aligned on load, so the low bits never matter.
`ifdef IF_EARLY_JUMP_EN
    assign w_unused_bits = {redirect_pc[1:0], 7'd0};
`else
    assign w_unused_bits = {redirect_pc[1:0], w_is_j, 6'd0};
`endif

    always_comb begin
        pc_d       = pc_q;
        id_inst_d  = id_inst_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (redirect) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_inst_d  = 32'h0;
            id_pc4_d   = 32'h0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
`ifdef IF_EARLY_JUMP_EN
            if (w_is_j) begin
                // The J is consumed here; only its own slot becomes a bubble.
                pc_d       = {w_pc4[31:28], rom_inst[25:0], 2'b00};
                id_inst_d  = 32'h0;
                id_pc4_d   = 32'h0;
                id_valid_d = 1'b0;
            end else begin
                pc_d       = w_pc4;
                id_inst_d  = rom_inst;
                id_pc4_d   = w_pc4;
                id_valid_d = 1'b1;
            end
`else
            pc_d       = w_pc4;
            id_inst_d  = rom_inst;
            id_pc4_d   = w_pc4;
            id_valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            id_inst_q  <= 32'h0;
            id_pc4_q   <= 32'h0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_inst_q  <= id_inst_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Directed self-checking bench for inst_fetch with a small ROM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;

    logic [31:0] rom [0:63];
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [31:0] W0 = 32'h0010_0443;
    localparam logic [31:0] W1 = 32'h0020_1025;
    localparam logic [31:0] W2 = 32'h0410_18E1;
    localparam logic [31:0] W3 = 32'h0420_2021;
    localparam logic [31:0] W4 = 32'h3800_41A8;
    localparam logic [31:0] W5 = 32'h3401_9DAA;
    localparam logic [31:0] W6 = 32'h00A4_3020;
    localparam logic [31:0] W7 = 32'h4800_0000;
    localparam logic [31:0] W8 = 32'h0010_3863;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .id_inst     (id_inst),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid)
    );

    always #5 clk = ~clk;

    always_comb rom_inst = rom[rom_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] inst, input logic [31:0] pc4,
                            input logic valid, input logic [31:0] addr);
        check({tag, ".inst"},  id_inst, inst);
        check({tag, ".pc4"},   id_pc4, pc4);
        check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, valid});
        check({tag, ".addr"},  rom_addr, addr);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = W3;
        rom[4] = W4; rom[5] = W5; rom[6] = W6; rom[7] = W7; rom[8] = W8;

        #1 rst = 1'b1;
        #2;
        check_id("reset", 32'h0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free run over the first words
        tick(); check_id("run0", W0, 32'h04, 1'b1, 32'h04);
        tick(); check_id("run1", W1, 32'h08, 1'b1, 32'h08);
        tick(); check_id("run2", W2, 32'h0C, 1'b1, 32'h0C);
        tick(); check_id("run3", W3, 32'h10, 1'b1, 32'h10);
        tick(); check_id("run4", W4, 32'h14, 1'b1, 32'h14);

        // Two-cycle stall
        stall = 1'b1;
        tick(); check_id("stall1", W4, 32'h14, 1'b1, 32'h14);
        tick(); check_id("stall2", W4, 32'h14, 1'b1, 32'h14);
        stall = 1'b0;
        tick(); check_id("release", W5, 32'h18, 1'b1, 32'h18);

        // Redirect beats a simultaneous stall; low target bits dropped
        redirect = 1'b1; redirect_pc = 32'h0000_0013; stall = 1'b1;
        tick(); check_id("redir", 32'h0, 32'h0, 1'b0, 32'h10);
        redirect = 1'b0; stall = 1'b0;
        tick(); check_id("redir_tgt", W4, 32'h14, 1'b1, 32'h14);
        tick(); check_id("seq5", W5, 32'h18, 1'b1, 32'h18);
        tick(); check_id("seq6", W6, 32'h1C, 1'b1, 32'h1C);

`ifdef IF_EARLY_JUMP_EN
        tick(); check_id("ejump", 32'h0, 32'h0, 1'b0, 32'h00);
        tick(); check_id("ejump_tgt", W0, 32'h04, 1'b1, 32'h04);
`else
        tick(); check_id("jflow", W7, 32'h20, 1'b1, 32'h20);
        tick(); check_id("wrongpath", W8, 32'h24, 1'b1, 32'h24);
        redirect = 1'b1; redirect_pc = 32'h0;
        tick(); check_id("jflush", 32'h0, 32'h0, 1'b0, 32'h00);
        redirect = 1'b0;
        tick(); check_id("jtgt", W0, 32'h04, 1'b1, 32'h04);
`endif

        tick(); check_id("pre1", W1, 32'h08, 1'b1, 32'h08);
        tick(); check_id("pre2", W2, 32'h0C, 1'b1, 32'h0C);
        tick(); check_id("pre3", W3, 32'h10, 1'b1, 32'h10);
        tick(); check_id("pre4", W4, 32'h14, 1'b1, 32'h14);

        // Asynchronous reset mid-cycle with stall and redirect pending
        #2;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0030;
        rst = 1'b1;
        #1;
        check_id("arst", 32'h0, 32'h0, 1'b0, 32'h00);
        #2;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        tick(); check_id("restart0", W0, 32'h04, 1'b1, 32'h04);
        tick(); check_id("restart1", W1, 32'h08, 1'b1, 32'h08);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
